mips_bus_lsu: RTL

Two-channel Avalon-MM bus master that sits between the multicycle MIPS core and the memory bus, replacing the core's direct address/read/write drive. It arbitrates between an instruction-fetch channel and a load/store channel and honours `waitrequest` stalls. It also generates byte enables for byte, half-word and word accesses, swaps between MIPS big-endian values and little-endian bus lanes, sign- or zero-extends loads, flags misaligned accesses, and optionally aborts stuck transfers after a timeout.

---
 rtl/codes.sv | 31 +++
 rtl/mem_lane_steer.sv | 65 ++++++
 rtl/mips_bus_lsu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/codes.sv
// rtl/codes.sv - shared types and helpers for the MIPS bus load/store unit
//
// Contents:
//   mem_size_t    - access size of a load/store (BYTE, HALF, WORD)
//   lsu_state_t   - bus master FSM states (IDLE, BUS, RESP)
//   is_misaligned - true when an access of the given size is not naturally aligned
package codes;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic mis;
    case (size)
      BYTE:    mis = 1'b0;
      HALF:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - byte-lane steering between big-endian values and little-endian bus lanes
//
// Purely combinational; serves both directions.
//   size, sign_ext, offset : access description (offset = byte address bits [1:0])
//   st_data                : right-justified store value
//   byteenable, bus_wdata  : bus lane enables and lane data for a store
//   bus_rdata              : raw bus read word (lane k = byte offset k)
//   ld_data                : big-endian reassembled, extended load value
module mem_lane_steer
  import codes::*;
(
  input  mem_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  output logic [3:0]  byteenable,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store direction: narrow stores are replicated so the selected lanes
  // carry the right bytes whatever the offset.
  always_comb begin
    byteenable = 4'b0000;
    bus_wdata  = 32'h0;
    case (size)
      BYTE: begin
        byteenable = 4'b0001 << offset;
        bus_wdata  = {4{st_data[7:0]}};
      end
      HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        bus_wdata  = {2{st_data[7:0], st_data[15:8]}};
      end
      default: begin
        byteenable = 4'b1111;
        bus_wdata  = {st_data[7:0], st_data[15:8], st_data[23:16], st_data[31:24]};
      end
    endcase
  end

  // Load direction: the lowest-addressed byte is the most significant one.
  always_comb begin
    ld_byte = 8'h00;
    case (offset)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = offset[1] ? {bus_rdata[23:16], bus_rdata[31:24]}
                        : {bus_rdata[7:0], bus_rdata[15:8]};
    ld_data = 32'h0;
    case (size)
      BYTE:    ld_data = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      HALF:    ld_data = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_data = {bus_rdata[7:0], bus_rdata[15:8], bus_rdata[23:16], bus_rdata[31:24]};
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// rtl/mips_bus_lsu.sv - two-channel Avalon-MM master for MIPS fetch and load/store
//
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   if_req_i/if_addr_i         : fetch request (always WORD), held until if_ack_o
//   if_ack_o/if_rdata_o/if_err_o : fetch completion pulse, instruction, error
//   d_req_i, d_we_i, d_size_i, d_signed_i, d_addr_i, d_wdata_i : load/store request
//   d_ack_o/d_rdata_o/d_err_o  : load/store completion pulse, extended load value, error
//   address, read, write, writedata, byteenable, readdata, waitrequest : Avalon-MM master
//   busy_o                     : high whenever the FSM is not IDLE
module mips_bus_lsu
  import codes::*;
#(
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT       = 0,
  parameter int DATA_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  mem_size_t         d_size_i,
  input  logic              d_signed_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_ack_o,
  output logic [31:0]       d_rdata_o,
  output logic              d_err_o,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  lsu_state_t        state;
  logic              chan_d;     // 1 = current transfer belongs to the data channel
  logic              last_data;  // last grant went to the data channel
  mem_size_t         size_q;
  logic              signed_q;
  logic              we_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              grant_d;
  logic              grant_if;
  mem_size_t         req_size;
  logic [ADDR_W-1:0] req_addr;
  logic              req_signed;
  logic              req_we;
  logic              req_mis;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              timeout_hit;

  mem_size_t         steer_size;
  logic              steer_signed;
  logic [1:0]        steer_off;
  logic [3:0]        steer_be;
  logic [31:0]       steer_wdata;
  logic [31:0]       steer_ld;

  // Data wins a collision under fixed priority; under round-robin it wins
  // only when fetch had the previous grant.
  always_comb begin
    grant_d    = d_req_i && (!if_req_i || (DATA_PRIORITY != 0) || !last_data);
    grant_if   = if_req_i && !grant_d;
    req_size   = grant_d ? d_size_i : WORD;
    req_addr   = grant_d ? d_addr_i : if_addr_i;
    req_signed = grant_d && d_signed_i;
    req_we     = grant_d && d_we_i;
    req_mis    = is_misaligned(req_size, req_addr[1:0]);
  end

  // Counter saturates at TIMEOUT; the abort fires on the wait cycle that
  // brings it to TIMEOUT. With TIMEOUT=0 CNT_MAX is 0 and it never moves.
  always_comb begin
    cnt_nxt     = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    timeout_hit = (TIMEOUT > 0) && waitrequest && (cnt_nxt == CNT_MAX);
  end

  // One steering instance: in IDLE it shapes the incoming store for the
  // bus registers, in BUS it decodes readdata with the latched attributes.
  always_comb begin
    steer_size   = (state == IDLE) ? req_size       : size_q;
    steer_signed = (state == IDLE) ? req_signed     : signed_q;
    steer_off    = (state == IDLE) ? req_addr[1:0]  : off_q;
  end

  mem_lane_steer u_steer (
    .size       (steer_size),
    .sign_ext   (steer_signed),
    .offset     (steer_off),
    .st_data    (d_wdata_i),
    .byteenable (steer_be),
    .bus_wdata  (steer_wdata),
    .bus_rdata  (readdata),
    .ld_data    (steer_ld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      chan_d     <= 1'b0;
      last_data  <= 1'b0;
      size_q     <= WORD;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= 2'b00;
      wait_cnt   <= '0;
      address    <= '0;
      writedata  <= 32'h0;
      byteenable <= 4'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      if_ack_o   <= 1'b0;
      if_rdata_o <= 32'h0;
      if_err_o   <= 1'b0;
      d_ack_o    <= 1'b0;
      d_rdata_o  <= 32'h0;
      d_err_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            chan_d    <= grant_d;
            last_data <= grant_d;
            size_q    <= req_size;
            signed_q  <= req_signed;
            we_q      <= req_we;
            off_q     <= req_addr[1:0];
            wait_cnt  <= '0;
            busy_o    <= 1'b1;
            if (req_mis) begin
              // No bus cycle: answer with an error straight away.
              state <= RESP;
              if (grant_d) begin
                d_ack_o <= 1'b1;
                d_err_o <= 1'b1;
              end else begin
                if_ack_o <= 1'b1;
                if_err_o <= 1'b1;
              end
            end else begin
              state      <= BUS;
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable <= steer_be;
              writedata  <= steer_wdata;
              read       <= !req_we;
              write      <= req_we;
            end
          end
        end
        BUS: begin
          if (waitrequest) begin
            wait_cnt <= cnt_nxt;
          end
          // Inside this branch waitrequest=1 only on a timeout abort,
          // so it doubles as the error flag.
          if (!waitrequest || timeout_hit) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= RESP;
            if (chan_d) begin
              d_ack_o <= 1'b1;
              d_err_o <= waitrequest;
              if (!waitrequest && !we_q) begin
                d_rdata_o <= steer_ld;
              end
            end else begin
              if_ack_o <= 1'b1;
              if_err_o <= waitrequest;
              if (!waitrequest) begin
                if_rdata_o <= steer_ld;
              end
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          if_err_o <= 1'b0;
          d_err_o  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
